// File: rtl/ddr2_local_arbiter.sv
// Two-port round-robin arbiter in front of a DDR2 controller local interface.
// Latency: request to local_* is combinational; read returns are routed in the same cycle.
// Backpressure: local_ready=0 locks the current selection until accepted; reads stall at TAG_DEPTH outstanding.
// Optional build macro DDR2_ARB_FIXED_PRI_EN: port 0 always wins when eligible and unlocked.
module ddr2_local_arbiter #(
  parameter int DATA_W    = 160,
  parameter int ADDR_W    = 23,
  parameter int TAG_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                p0_read_req,
  input  logic                p0_write_req,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_be,
  output logic                p0_ready,
  output logic                p0_rdata_valid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_read_req,
  input  logic                p1_write_req,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_be,
  output logic                p1_ready,
  output logic                p1_rdata_valid,
  output logic [DATA_W-1:0]   p1_rdata,
  input  logic                local_ready,
  input  logic                local_init_done,
  input  logic                local_rdata_valid,
  input  logic [DATA_W-1:0]   local_rdata,
  output logic                local_read_req,
  output logic                local_write_req,
  output logic                local_burstbegin,
  output logic                local_size,
  output logic                local_cs_addr,
  output logic [12:0]         local_row_addr,
  output logic [1:0]          local_bank_addr,
  output logic [7:0]          local_col_addr,
  output logic [DATA_W-1:0]   local_wdata,
  output logic [DATA_W/8-1:0] local_be,
  output logic                rd_tag_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAG_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TAG_DEPTH);

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t                state, state_nxt;
  logic                  lock_port, lock_port_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [TAG_DEPTH-1:0]  tag_mem;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;

  logic                  grant_en, rd_room, elig0, elig1;
  logic                  sel_vld, sel_port, sel_rd, sel_wr, accept, push, pop;
  logic [ADDR_W-1:0]     sel_addr;

  // Grants are blocked until the controller has finished init (and during reset).
  assign grant_en = local_init_done & reset_n;
  // Room is judged on the registered count: a same-cycle pop does not free a slot.
  assign rd_room  = (count != CNT_FULL);
  assign elig0    = p0_write_req | (p0_read_req & rd_room);
  assign elig1    = p1_write_req | (p1_read_req & rd_room);

  // Port selection: a locked selection is held, otherwise arbitrate.
  always_comb begin
    sel_vld  = 1'b0;
    sel_port = 1'b0;
    if (grant_en) begin
      if (state == ST_LOCKED) begin
        sel_port = lock_port;
        sel_vld  = lock_port ? elig1 : elig0;
      end else if (elig0 && elig1) begin
        sel_vld  = 1'b1;
`ifdef DDR2_ARB_FIXED_PRI_EN
        sel_port = 1'b0;
`else
        sel_port = ~last_grant;
`endif
      end else if (elig0) begin
        sel_vld  = 1'b1;
        sel_port = 1'b0;
      end else if (elig1) begin
        sel_vld  = 1'b1;
        sel_port = 1'b1;
      end
    end
  end

  // Steer the selected port onto the controller interface; read+write counts as write.
  assign sel_rd           = sel_port ? p1_read_req  : p0_read_req;
  assign sel_wr           = sel_port ? p1_write_req : p0_write_req;
  assign sel_addr         = sel_port ? p1_addr      : p0_addr;
  assign local_wdata      = sel_port ? p1_wdata     : p0_wdata;
  assign local_be         = sel_port ? p1_be        : p0_be;
  assign local_write_req  = sel_vld & sel_wr;
  assign local_read_req   = sel_vld & sel_rd & ~sel_wr;
  assign local_burstbegin = local_read_req | local_write_req;
  assign local_row_addr   = sel_addr[22:10];
  assign local_bank_addr  = sel_addr[9:8];
  assign local_col_addr   = sel_addr[7:0];
  assign local_cs_addr    = 1'b0;
  assign local_size       = 1'b1;

  assign accept   = sel_vld & local_ready;
  assign p0_ready = accept & ~sel_port;
  assign p1_ready = accept & sel_port;

  // Lock / grant-history next state.
  always_comb begin
    state_nxt      = state;
    lock_port_nxt  = lock_port;
    last_grant_nxt = last_grant;
    if (accept) begin
      state_nxt      = ST_OPEN;
      last_grant_nxt = sel_port;
    end else if (sel_vld) begin
      state_nxt      = ST_LOCKED;
      lock_port_nxt  = sel_port;
    end else begin
      state_nxt      = ST_OPEN;
    end
  end

  // Arbiter state register; last_grant resets to 1 so port 0 wins first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_OPEN;
      lock_port  <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      lock_port  <= lock_port_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Tag FIFO: one bit per outstanding read records the requesting port.
  assign push = accept & local_read_req;
  assign pop  = local_rdata_valid & (count != '0);

  assign p0_rdata_valid = pop & ~tag_mem[rd_ptr];
  assign p1_rdata_valid = pop &  tag_mem[rd_ptr];
  assign p0_rdata       = local_rdata;
  assign p1_rdata       = local_rdata;

  // Tag storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= sel_port;
  end

  // FIFO pointers, occupancy and the sticky unexpected-return flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_tag_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (local_rdata_valid && count == '0) rd_tag_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Directed bench for ddr2_local_arbiter with a transaction-level reference model.
// Model: pending-port lock, grant history, queue of outstanding read tags.
// Every cycle is compared at the falling edge; inputs change 1 time unit after the rising edge.
module tb_ddr2_local_arbiter;
  localparam int DATA_W    = 160;
  localparam int ADDR_W    = 23;
  localparam int BE_W      = DATA_W / 8;
  localparam int TAG_DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic p0_read_req, p0_write_req, p1_read_req, p1_write_req;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, local_rdata, local_wdata;
  logic [BE_W-1:0]   p0_be, p1_be, local_be;
  logic p0_ready, p1_ready, p0_rdata_valid, p1_rdata_valid;
  logic local_ready, local_init_done, local_rdata_valid;
  logic local_read_req, local_write_req, local_burstbegin, local_size, local_cs_addr;
  logic [12:0] local_row_addr;
  logic [1:0]  local_bank_addr;
  logic [7:0]  local_col_addr;
  logic rd_tag_err;

  ddr2_local_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_read_req(p0_read_req), .p0_write_req(p0_write_req), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_be(p0_be), .p0_ready(p0_ready),
    .p0_rdata_valid(p0_rdata_valid), .p0_rdata(p0_rdata),
    .p1_read_req(p1_read_req), .p1_write_req(p1_write_req), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_be(p1_be), .p1_ready(p1_ready),
    .p1_rdata_valid(p1_rdata_valid), .p1_rdata(p1_rdata),
    .local_ready(local_ready), .local_init_done(local_init_done),
    .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata),
    .local_read_req(local_read_req), .local_write_req(local_write_req),
    .local_burstbegin(local_burstbegin), .local_size(local_size),
    .local_cs_addr(local_cs_addr), .local_row_addr(local_row_addr),
    .local_bank_addr(local_bank_addr), .local_col_addr(local_col_addr),
    .local_wdata(local_wdata), .local_be(local_be), .rd_tag_err(rd_tag_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int last_grant = 1;
  int held = -1;
  int tags[$];
  bit err_m = 1'b0;

  // Values captured at the last compare, used by hand-computed literal checks.
  logic cap_p0_ready, cap_p1_ready, cap_p0_rv, cap_p1_rv, cap_lrd, cap_lwr, cap_err;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare DUT against the model, then advance the model.
  task automatic step();
    int sel;
    int rv_port;
    bit elig [2];
    bit rq [2];
    bit wq [2];
    bit exp_r, exp_w;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [BE_W-1:0]   be;
    @(negedge clk);
    rq[0] = p0_read_req;  rq[1] = p1_read_req;
    wq[0] = p0_write_req; wq[1] = p1_write_req;
    sel = -1;
    if (!reset_n) begin
      last_grant = 1; held = -1; tags.delete(); err_m = 1'b0;
    end else if (local_init_done) begin
      for (int n = 0; n < 2; n++) elig[n] = wq[n] || (rq[n] && tags.size() < TAG_DEPTH);
      if (held >= 0)              sel = elig[held] ? held : -1;
`ifdef DDR2_ARB_FIXED_PRI_EN
      else if (elig[0] && elig[1]) sel = 0;
`else
      else if (elig[0] && elig[1]) sel = 1 - last_grant;
`endif
      else if (elig[0])            sel = 0;
      else if (elig[1])            sel = 1;
    end
    exp_w   = (sel >= 0) && wq[sel];
    exp_r   = (sel >= 0) && rq[sel] && !wq[sel];
    rv_port = (reset_n && local_rdata_valid && tags.size() > 0) ? tags[0] : -1;

    chk("p0_ready", p0_ready, (sel == 0 && local_ready) ? 1 : 0);
    chk("p1_ready", p1_ready, (sel == 1 && local_ready) ? 1 : 0);
    chk("local_read_req", local_read_req, exp_r);
    chk("local_write_req", local_write_req, exp_w);
    chk("local_burstbegin", local_burstbegin, exp_r | exp_w);
    chk("local_size", local_size, 1);
    chk("local_cs_addr", local_cs_addr, 0);
    chk("p0_rdata_valid", p0_rdata_valid, (rv_port == 0) ? 1 : 0);
    chk("p1_rdata_valid", p1_rdata_valid, (rv_port == 1) ? 1 : 0);
    chk("p0_rdata", p0_rdata, local_rdata);
    chk("p1_rdata", p1_rdata, local_rdata);
    chk("rd_tag_err", rd_tag_err, err_m);
    if (sel >= 0) begin
      a  = (sel == 1) ? p1_addr  : p0_addr;
      wd = (sel == 1) ? p1_wdata : p0_wdata;
      be = (sel == 1) ? p1_be    : p0_be;
      chk("local_row_addr", local_row_addr, a / 1024);
      chk("local_bank_addr", local_bank_addr, (a / 256) % 4);
      chk("local_col_addr", local_col_addr, a % 256);
      chk("local_wdata", local_wdata, wd);
      chk("local_be", local_be, be);
    end
    cap_p0_ready = p0_ready; cap_p1_ready = p1_ready;
    cap_p0_rv = p0_rdata_valid; cap_p1_rv = p1_rdata_valid;
    cap_lrd = local_read_req; cap_lwr = local_write_req; cap_err = rd_tag_err;

    @(posedge clk);
    if (reset_n) begin
      if (local_rdata_valid) begin
        if (tags.size() > 0) void'(tags.pop_front());
        else err_m = 1'b1;
      end
      if (sel >= 0) begin
        if (local_ready) begin
          last_grant = sel;
          held = -1;
          if (exp_r) tags.push_back(sel);
        end else begin
          held = sel;
        end
      end else begin
        held = -1;
      end
    end
    #1;
    local_rdata = {local_rdata[DATA_W-33:0], local_rdata[DATA_W-1:DATA_W-32] + 32'h1111};
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; local_init_done = 1'b0; local_ready = 1'b1; local_rdata_valid = 1'b0;
    local_rdata = {5{32'hA5A5_0001}};
    p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
    p0_addr = 23'h5A_BC_D3; p1_addr = 23'h12_34_56;
    p0_wdata = {5{32'h0000_F00D}}; p1_wdata = {5{32'hBEEF_0000}};
    p0_be = 20'hF_0F0F; p1_be = 20'hA_AAAA;
    #2;
    steps(2);
    chk("lit_reset_err", cap_err, 0);
    chk("lit_reset_p0_ready", cap_p0_ready, 0);

    // Init not done: both request, nothing issued.
    reset_n = 1'b1; p0_read_req = 1; p1_read_req = 1;
    steps(2);
    chk("lit_noinit_rd", cap_lrd, 0);
    chk("lit_noinit_wr", cap_lwr, 0);
    local_init_done = 1'b1;
    step();
    chk("lit_first_grant_p0", cap_p0_ready, 1);
    step();
`ifdef DDR2_ARB_FIXED_PRI_EN
    chk("lit_fixed_g2_p0", cap_p0_ready, 1);
    step(); chk("lit_fixed_g3_p0", cap_p0_ready, 1);
    step(); chk("lit_fixed_g4_p0", cap_p0_ready, 1);
`else
    chk("lit_rr_g2_p1", cap_p1_ready, 1);
    step(); chk("lit_rr_g3_p0", cap_p0_ready, 1);
    step(); chk("lit_rr_g4_p1", cap_p1_ready, 1);
`endif
    p0_read_req = 0; p1_read_req = 0; local_rdata_valid = 1;
    step(); chk("lit_ret1_p0", cap_p0_rv, 1);
    step();
`ifndef DDR2_ARB_FIXED_PRI_EN
    chk("lit_ret2_p1", cap_p1_rv, 1);
`endif
    steps(2);
    local_rdata_valid = 0;

    // Lock: p1 write stalled 3 cycles, p0 arrives in cycle 2.
    local_ready = 0; p1_write_req = 1;
    step();
    p0_read_req = 1;
    steps(2);
    chk("lit_lock_wr", cap_lwr, 1);
    chk("lit_lock_p0_ready", cap_p0_ready, 0);
    local_ready = 1;
    step(); chk("lit_lock_p1_acc", cap_p1_ready, 1);
    p1_write_req = 0;
    step(); chk("lit_lock_p0_next", cap_p0_ready, 1);
    p0_read_req = 0; local_rdata_valid = 1;
    step();
    local_rdata_valid = 0;

    // Tag FIFO full: 9th read holds until a return frees a slot.
    p0_read_req = 1; p0_write_req = 0;
    steps(8);
    step(); chk("lit_full_hold", cap_p0_ready, 0);
    local_rdata_valid = 1;
    step();
    chk("lit_full_pop_hold", cap_p0_ready, 0);
    chk("lit_full_pop_rv", cap_p0_rv, 1);
    local_rdata_valid = 0;
    step(); chk("lit_full_9th_acc", cap_p0_ready, 1);
    p0_read_req = 0; p1_write_req = 1;
    step(); chk("lit_full_wr_ok", cap_p1_ready, 1);
    p1_write_req = 0;
    // Push and pop together at count 7 leave the count at 7.
    local_rdata_valid = 1; step();
    p0_read_req = 1; step();
    local_rdata_valid = 0; step();
    step(); chk("lit_pp_full_hold", cap_p0_ready, 0);
    p0_read_req = 0; local_rdata_valid = 1;
    steps(8);
    step(); chk("lit_empty_drop", cap_p0_rv | cap_p1_rv, 0);
    local_rdata_valid = 0;
    step(); chk("lit_err_set", cap_err, 1);
    steps(2); chk("lit_err_sticky", cap_err, 1);

    // Reset with 3 reads outstanding discards the tags.
    p0_read_req = 1; steps(3); p0_read_req = 0;
    reset_n = 0; p1_write_req = 1;
    step(); chk("lit_rst_err_clr", cap_err, 0);
    chk("lit_rst_ready", cap_p1_ready, 0);
    p1_write_req = 0; reset_n = 1; local_rdata_valid = 1;
    step(); chk("lit_rst_drop", cap_p0_rv, 0);
    local_rdata_valid = 0;
    step(); chk("lit_rst_err_set", cap_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr2_local_arbiter.md
DDR2_LOCAL_ARBITER -- requirements
Module: ddr2_local_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_W, default 160, local data width; ADDR_W, default 23, flat word address {row[12:0], bank[1:0], col[7:0]}; TAG_DEPTH, default 8, maximum outstanding reads (power of 2).
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- pN_read_req, pN_write_req  in  1 each  per-port requests, N = 0 and 1.
- pN_addr  in  ADDR_W  per-port address.
- pN_wdata  in  DATA_W  per-port write data.
- pN_be  in  DATA_W/8  per-port byte enables.
- pN_ready  out  1  per-port accept; a request is taken when pN_ready is high in the same cycle.
- pN_rdata_valid  out  1  per-port read-return strobe.
- pN_rdata  out  DATA_W  per-port read data.
- local_ready  in  1  controller accept.
- local_init_done  in  1  controller initialisation complete.
- local_rdata_valid  in  1  controller read-return strobe.
- local_rdata  in  DATA_W  controller read data.
- local_read_req, local_write_req, local_burstbegin  out  1 each  controller requests.
- local_size  out  1  burst size.
- local_cs_addr  out  1  chip select.
- local_row_addr  out  13  row address.
- local_bank_addr  out  2  bank address.
- local_col_addr  out  8  column address.
- local_wdata  out  DATA_W  write data to controller.
- local_be  out  DATA_W/8  byte enables to controller.
- rd_tag_err  out  1  sticky unexpected read-return flag.

Function
REQ-003 No port SHALL be granted, and local_read_req/local_write_req SHALL be 0, while local_init_done=0.
REQ-004 A port is eligible when it asserts read_req or write_req; a read is eligible only when the outstanding count is below TAG_DEPTH.
REQ-005 The arbiter SHALL be round-robin: when both ports are eligible and unlocked, the port other than last_grant SHALL win.
REQ-006 The selected port's request, address, wdata and be SHALL drive the local_* outputs combinationally.
REQ-007 Field mapping SHALL be: local_row_addr=addr[22:10], local_bank_addr=addr[9:8], local_col_addr=addr[7:0], local_cs_addr=0, local_size=1.
REQ-008 local_burstbegin SHALL equal local_read_req|local_write_req.
REQ-009 If a selected request is presented while local_ready=0, the lock register SHALL hold that selection until local_ready=1 (state LOCKED); otherwise the state is OPEN.
REQ-010 Acceptance: pN_ready=1 only for the selected port and only in a cycle with local_ready=1; on acceptance last_grant<=N, lock clears, and state returns to OPEN.
REQ-011 If a port asserts both read_req and write_req, the request SHALL be treated as a write.
REQ-012 On each accepted read, the port index SHALL be pushed into a TAG_DEPTH-entry tag FIFO.
REQ-013 On each local_rdata_valid, the FIFO head SHALL be popped and pN_rdata_valid asserted for the tagged port in the same cycle; pN_rdata=local_rdata for both ports.
REQ-014 Simultaneous push and pop SHALL leave the count unchanged, including when count=TAG_DEPTH-1.
REQ-015 A read SHALL be ineligible when count=TAG_DEPTH, even if a pop occurs in that cycle; writes remain eligible.
REQ-016 local_rdata_valid with an empty FIFO SHALL be dropped (no pN_rdata_valid) and SHALL set rd_tag_err, which stays set until reset.
REQ-017 FIFO read and write pointers SHALL wrap modulo TAG_DEPTH.

Reset
REQ-018 On reset_n low, asynchronously: last_grant=1 (port 0 wins first), lock cleared, state OPEN, FIFO empty with count 0, rd_tag_err=0, all pN_ready/pN_rdata_valid=0.
REQ-019 Reset asserted mid-operation SHALL discard all outstanding tags; read returns arriving after reset fall under REQ-016.

Configuration
REQ-020 With DDR2_ARB_FIXED_PRI_EN defined, port 0 SHALL win whenever eligible and unlocked, and last_grant SHALL be ignored.
REQ-021 Without DDR2_ARB_FIXED_PRI_EN, REQ-005 round-robin SHALL apply.
REQ-022 Locking (REQ-009) SHALL apply in both builds.

Verification
REQ-023 Both ports read continuously, local_ready=1 -> grants alternate 0,1,0,1; returns route p0,p1,p0,p1 in order.
REQ-024 p1 write with local_ready=0 for 3 cycles, p0 requests in cycle 2 -> local_* stays on p1 until accepted; p0 is granted next cycle.
REQ-025 9 reads with no returns -> the 9th read is held with pN_ready=0; one local_rdata_valid -> the 9th is accepted the following cycle.
REQ-026 local_rdata_valid with 0 outstanding -> no pN_rdata_valid; rd_tag_err=1 and stays 1.
REQ-027 local_init_done=0 with both ports requesting -> local_read_req=0 and local_write_req=0; the first grant after init_done rises goes to p0.
REQ-028 Build with DDR2_ARB_FIXED_PRI_EN, both ports requesting for 4 cycles -> p0 granted all 4; reset asserted with 3 reads outstanding -> count=0 after reset.
